// File: rtl/uart_tx_fifo_if.sv
// Producer-side write port of the UART transmit FIFO (valid/ready handshake).
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 valid_in;
  logic [DATA_BITS-1:0] val_in;
  logic                 ready_out;

  modport master (output valid_in, output val_in, input ready_out);
  modport slave  (input valid_in, input val_in, output ready_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO; queued words leave back-to-back.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line high, waiting for a queued word
// S_START  | start bit (low)
// S_DATA   | data bits, LSB first
// S_PARITY | parity bit (only reached when parity is enabled)
// S_STOP   | stop bit(s) high; chains straight into the next start bit
module uart_tx_fifo #(
  parameter int CLK_HZ     = 65_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DIVISOR    = CLK_HZ / BAUD_RATE,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  uart_tx_fifo_if.slave               wr,
  output logic                        data_out,
  output logic                        busy_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BAUD_RELOAD = 32'(DIVISOR - 1);
  localparam logic [3:0]  DATA_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST   = 4'(STOP_BITS - 1);
  localparam logic [AW:0] DEPTH       = (AW + 1)'(FIFO_DEPTH);
  localparam logic        ODD_PARITY  = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [31:0]          baud_q, baud_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 full, empty, push, pop, load;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign full         = (count_q == DEPTH);
  assign empty        = (count_q == '0);
  // A full FIFO refuses writes even when a pop happens on the same edge.
  assign push         = wr.valid_in && !full;
  assign head         = mem_q[rd_ptr_q];
  assign head_par     = (^head) ^ ODD_PARITY;
  assign wr.ready_out = !full;

  assign data_out       = tx_q;
  assign busy_out       = (state_q != S_IDLE);
  assign fifo_count_out = count_q;

  // FIFO storage: written on an accepted push, never reset.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= wr.val_in;
  end

  // FIFO pointers and occupancy; a push and pop together keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Framing FSM with down-counting baud timer; pop/load shared by IDLE and STOP.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    load      = 1'b0;
    if (state_q == S_IDLE) begin
      tx_d = 1'b1;
      if (!empty) load = 1'b1;
    end else if (baud_q != '0) begin
      baud_d = baud_q - 1'b1;
    end else begin
      baud_d = BAUD_RELOAD;
      case (state_q)
        S_START: begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = DATA_LAST;
        end
        S_DATA: begin
          if (bit_cnt_q != '0) begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else if (PARITY != 0) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d   = S_STOP;
            tx_d      = 1'b1;
            bit_cnt_d = STOP_LAST;
          end
        end
        S_PARITY: begin
          state_d   = S_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = STOP_LAST;
        end
        S_STOP: begin
          tx_d = 1'b1;
          if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Parity is taken from the popped word so later writes cannot disturb it.
    if (load) begin
      state_d = S_START;
      shift_d = head;
      par_d   = head_par;
      tx_d    = 1'b0;
      baud_d  = BAUD_RELOAD;
    end
  end

  assign pop = load;

  // State registers; reset forces the line high and flushes the FIFO.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      baud_q    <= BAUD_RELOAD;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameter sets, frame vector table and a
// per-cycle line scoreboard on the main instance.
module tb_uart_tx_fifo;
  localparam int D = 4;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  always #5 clk_in = ~clk_in;

  uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(5)) if_c ();

  logic       line_a, busy_a, line_b, busy_b, line_c, busy_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  uart_tx_fifo #(.DIVISOR(D), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk_in(clk_in), .rst_n_in(rst_n), .wr(if_a),
    .data_out(line_a), .busy_out(busy_a), .fifo_count_out(cnt_a));
  uart_tx_fifo #(.DIVISOR(D), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk_in(clk_in), .rst_n_in(rst_n), .wr(if_b),
    .data_out(line_b), .busy_out(busy_b), .fifo_count_out(cnt_b));
  uart_tx_fifo #(.DIVISOR(D), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .clk_in(clk_in), .rst_n_in(rst_n), .wr(if_c),
    .data_out(line_c), .busy_out(busy_c), .fifo_count_out(cnt_c));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for dut_a: each accepted word appends its frame, one entry per
  // clock cycle ({first cycle of frame, line level}); one entry popped per cycle.
  logic [1:0] sb_q[$];
  int         sb_cnt  = 0;
  logic       sb_pend = 1'b0;
  logic [7:0] sb_word = 8'h00;

  always @(negedge clk_in) begin
    logic [1:0]  e;
    logic        exp_line, exp_busy;
    logic [10:0] fr;
    if (!rst_n) begin
      sb_q.delete();
      sb_cnt  = 0;
      sb_pend = 1'b0;
      check("rst_line", line_a, 1);
      check("rst_busy", busy_a, 0);
      check("rst_count", cnt_a, 0);
      check("rst_ready", if_a.ready_out, 1);
    end else begin
      exp_line = 1'b1;
      exp_busy = 1'b0;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_line = e[0];
        exp_busy = 1'b1;
        if (e[1]) sb_cnt--;
      end
      if (sb_pend) begin
        fr = {1'b1, ^sb_word, sb_word, 1'b0};
        for (int b = 0; b < 11; b++)
          for (int c = 0; c < D; c++)
            sb_q.push_back({(b == 0 && c == 0), fr[b]});
        sb_cnt++;
      end
      check("sb_line", line_a, exp_line);
      check("sb_busy", busy_a, exp_busy);
      check("sb_count", cnt_a, sb_cnt);
      check("sb_ready", if_a.ready_out, sb_cnt < 4);
      sb_pend = if_a.valid_in && (sb_cnt < 4);
      sb_word = if_a.val_in;
    end
  end

  typedef struct {
    int         sel;
    logic [8:0] word;
    string      seq;
  } vec_t;
  vec_t vecs[7];

  task automatic drive(input int s, input logic v, input logic [8:0] w);
    case (s)
      0:       begin if_a.valid_in = v; if_a.val_in = w[7:0]; end
      1:       begin if_b.valid_in = v; if_b.val_in = w[7:0]; end
      default: begin if_c.valid_in = v; if_c.val_in = w[4:0]; end
    endcase
  endtask

  function automatic logic line_sel(input int s);
    case (s)
      0:       return line_a;
      1:       return line_b;
      default: return line_c;
    endcase
  endfunction

  function automatic logic busy_sel(input int s);
    case (s)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic push_a(input logic [7:0] w);
    if_a.valid_in = 1'b1;
    if_a.val_in   = w;
    @(posedge clk_in); #1;
    if_a.valid_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while ((busy_a || cnt_a != 0) && n < budget);
    check("drain_busy", busy_a, 0);
    check("drain_model_empty", sb_q.size(), 0);
    @(posedge clk_in); #1;
  endtask

  initial begin
    int         idx, n, peak, last_acc;
    logic       acc, saw_full;
    logic [7:0] fw [6];

    vecs[0] = '{0, 9'h0A5, "01010010101"};
    vecs[1] = '{0, 9'h000, "00000000001"};
    vecs[2] = '{0, 9'h001, "01000000011"};
    vecs[3] = '{1, 9'h0FF, "011111111111"};
    vecs[4] = '{1, 9'h000, "000000000111"};
    vecs[5] = '{2, 9'h013, "011001011"};
    vecs[6] = '{2, 9'h01F, "011111011"};

    drive(0, 1'b0, 9'h0);
    drive(1, 1'b0, 9'h0);
    drive(2, 1'b0, 9'h0);

    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk_in);
    #1;
    check("idle_line", line_a, 1);
    check("idle_ready", if_a.ready_out, 1);
    check("idle_count", cnt_a, 0);
    check("idle_busy", busy_a, 0);

    // Frame table: one word at a time, every cycle of the frame compared.
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].sel, 1'b1, vecs[v].word);
      @(posedge clk_in); #1;
      drive(vecs[v].sel, 1'b0, vecs[v].word);
      @(negedge clk_in);
      check($sformatf("vec%0d_latency", v), line_sel(vecs[v].sel), 1);
      for (int i = 0; i < vecs[v].seq.len() * D; i++) begin
        @(negedge clk_in);
        check($sformatf("vec%0d_cycle%0d", v, i), line_sel(vecs[v].sel), vecs[v].seq[i / D] == "1");
        check($sformatf("vec%0d_busy%0d", v, i), busy_sel(vecs[v].sel), 1);
      end
      @(negedge clk_in);
      check($sformatf("vec%0d_end_line", v), line_sel(vecs[v].sel), 1);
      check($sformatf("vec%0d_end_busy", v), busy_sel(vecs[v].sel), 0);
      @(posedge clk_in); #1;
    end
    check("b_count_end", cnt_b, 0);
    check("c_count_end", cnt_c, 0);

    // Fill: six words with valid held high into a 4-deep FIFO.
    fw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0; n = 0; peak = 0; last_acc = 0; saw_full = 1'b0;
    if_a.valid_in = 1'b1;
    if_a.val_in   = fw[0];
    while (idx < 6 && n < 400) begin
      @(negedge clk_in);
      acc = if_a.ready_out;
      if (int'(cnt_a) > peak) peak = int'(cnt_a);
      if (!if_a.ready_out) saw_full = 1'b1;
      @(posedge clk_in); #1;
      n++;
      if (acc) begin
        idx++;
        last_acc = n;
        if (idx < 6) if_a.val_in = fw[idx];
      end
    end
    if_a.valid_in = 1'b0;
    check("fill_accepted", idx, 6);
    check("fill_peak", peak, 4);
    check("fill_saw_full", saw_full, 1);
    check("fill_last_accept_edge", last_acc, 47);
    wait_drain(400);

    // Wrap: hold occupancy at 2 by pushing on each pop edge, 20 words total.
    push_a(8'h00);
    push_a(8'h07);
    push_a(8'h0E);
    repeat (42) @(posedge clk_in);
    #1;
    for (int j = 3; j < 20; j++) begin
      push_a(8'(j * 7));
      check($sformatf("wrap_count%0d", j), cnt_a, 2);
      if (j < 19) begin
        repeat (43) @(posedge clk_in);
        #1;
      end
    end
    wait_drain(300);

    // Reset mid data bit with three words queued.
    push_a(8'hC1);
    push_a(8'hC2);
    push_a(8'hC3);
    push_a(8'hC4);
    check("pre_reset_count", cnt_a, 3);
    repeat (8) @(posedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_line", line_a, 1);
    check("mid_reset_count", cnt_a, 0);
    check("mid_reset_busy", busy_a, 0);
    check("mid_reset_ready", if_a.ready_out, 1);
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk_in);
    #1;
    check("post_reset_line", line_a, 1);
    check("post_reset_busy", busy_a, 0);
    check("post_reset_count", cnt_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
